// File: rtl/int_to_double_pkg.sv
// rtl/int_to_double_pkg.sv - shared binary64 field constants used by the int/double converters
package int_to_double_pkg;

    localparam int          EXP_WIDTH     = 11;
    localparam int          MANT_WIDTH    = 52;
    localparam logic [10:0] EXP_BIAS      = 11'd1023;
    localparam logic [63:0] FP64_POS_ZERO = 64'h0000_0000_0000_0000;

endpackage

// File: rtl/int_to_double.sv
// rtl/int_to_double.sv - 64-bit signed integer to IEEE-754 binary64 converter, one operand in flight
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           asynchronous active-high reset
//   input_a       64-bit two's-complement operand
//   input_a_stb   upstream has a valid operand
//   input_a_ack   converter is ready to take an operand
//   output_z      binary64 result {sign, exponent[10:0], mantissa[51:0]}
//   output_z_stb  output_z is valid
//   output_z_ack  downstream takes output_z
module int_to_double
    import int_to_double_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [63:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [2:0] {
        GET_A,
        SPECIAL,
        NORMALISE,
        ROUND,
        PACK,
        PUT_Z
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [63:0]             r_a;
    logic [63:0]             r_m;
    logic [EXP_WIDTH-1:0]    r_exp;
    logic                    r_sign;
    logic                    r_zero;
    logic [MANT_WIDTH-1:0]   r_mant;
    logic [63:0]             r_z;
    logic                    r_ack;
    logic                    r_stb;

    logic [63:0]             w_mag;
    logic                    w_guard;
    logic                    w_round;
    logic                    w_sticky;
    logic                    w_inc;
    logic [MANT_WIDTH:0]     w_mant_sum;

    // -2^63 negates to itself, which read as unsigned is the correct magnitude.
    assign w_mag = r_a[63] ? (~r_a + 64'd1) : r_a;

    assign w_guard    = r_m[10];
    assign w_round    = r_m[9];
    assign w_sticky   = |r_m[8:0];
    assign w_inc      = w_guard && (w_round || w_sticky || r_m[11]);
    // r_m[63] is always 1 here, so a carry out of the 52 fraction bits is
    // exactly a carry out of the full 53-bit significand.
    assign w_mant_sum = {1'b0, r_m[62:11]} + {{MANT_WIDTH{1'b0}}, w_inc};

    always_comb begin
        w_next = r_state;
        case (r_state)
            GET_A:     if (input_a_stb && r_ack) w_next = SPECIAL;
            // Zero skips normalisation (it would never terminate) but still
            // passes through PACK so output_z is only ever loaded there.
            SPECIAL:   w_next = (r_a == 64'd0) ? PACK : NORMALISE;
            NORMALISE: if (r_m[63]) w_next = ROUND;
            ROUND:     w_next = PACK;
            PACK:      w_next = PUT_Z;
            PUT_Z:     if (output_z_ack && r_stb) w_next = GET_A;
            default:   w_next = GET_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= GET_A;
            r_a     <= 64'd0;
            r_m     <= 64'd0;
            r_exp   <= '0;
            r_sign  <= 1'b0;
            r_zero  <= 1'b0;
            r_mant  <= '0;
            r_z     <= 64'd0;
            r_ack   <= 1'b0;
            r_stb   <= 1'b0;
        end else begin
            r_state <= w_next;
            // Handshake flags are registered from the next state so ack and
            // stb change on the same edge as the state and can never overlap.
            r_ack   <= (w_next == GET_A);
            r_stb   <= (w_next == PUT_Z);
            case (r_state)
                GET_A: begin
                    if (input_a_stb && r_ack) r_a <= input_a;
                end
                SPECIAL: begin
                    r_zero <= (r_a == 64'd0);
                    r_sign <= r_a[63];
                    r_m    <= w_mag;
                    r_exp  <= 11'd63;
                end
                NORMALISE: begin
                    if (!r_m[63]) begin
                        r_m   <= {r_m[62:0], 1'b0};
                        r_exp <= r_exp - 11'd1;
                    end
                end
                ROUND: begin
                    if (w_mant_sum[MANT_WIDTH]) begin
                        r_mant <= '0;
                        r_exp  <= r_exp + 11'd1;
                    end else begin
                        r_mant <= w_mant_sum[MANT_WIDTH-1:0];
                    end
                end
                PACK: begin
                    r_z <= r_zero ? FP64_POS_ZERO : {r_sign, r_exp + EXP_BIAS, r_mant};
                end
                default: ;
            endcase
        end
    end

    assign input_a_ack  = r_ack;
    assign output_z_stb = r_stb;
    assign output_z     = r_z;

endmodule

// File: tb/tb_int_to_double.sv
// tb/tb_int_to_double.sv - self-checking bench for int_to_double
module tb_int_to_double;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [63:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    int_to_double dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    // Reference: the simulator's own integer-to-real conversion (round to nearest even).
    function automatic logic [63:0] model_z(input logic [63:0] a);
        longint s;
        real    r;
        s = a;
        r = real'(s);
        return $realtobits(r);
    endfunction

    function automatic int model_lat(input logic [63:0] a);
        logic [63:0] mag;
        if (a == 64'd0) return 2;
        mag = a[63] ? (64'd0 - a) : a;
        for (int i = 63; i >= 0; i--)
            if (mag[i]) return 4 + (63 - i);
        return -1;
    endfunction

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        v = {$urandom, $urandom};
        v = v >> $urandom_range(0, 63);
        case ($urandom_range(0, 9))
            0: v = 64'd0;
            1: v = (64'd1 << $urandom_range(53, 62)) | 64'($urandom_range(0, 7));
            default: ;
        endcase
        if ($urandom_range(0, 1) == 1) v = 64'd0 - v;
        return v;
    endfunction

    task automatic send(input logic [63:0] a, output bit ok);
        ok          = 1'b0;
        input_a     = a;
        input_a_stb = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (input_a_ack) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        input_a_stb = 1'b0;
    endtask

    task automatic recv(output logic [63:0] z, output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        z   = 64'd0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            lat++;
            if (output_z_stb) begin
                ok = 1'b1;
                z  = output_z;
                break;
            end
        end
    endtask

    task automatic run_one(input logic [63:0] a, input int stall,
                           output logic [63:0] z, output int lat, output bit ok);
        bit ok_s, ok_r;
        output_z_ack = (stall == 0);
        send(a, ok_s);
        recv(z, lat, ok_r);
        ok = ok_s && ok_r;
        if (ok_r) begin
            repeat (stall) @(posedge clk);
            #1;
            output_z_ack = 1'b1;
            @(posedge clk);
            #1;
        end
        output_z_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        input_a      = 64'd0;
        input_a_stb  = 1'b0;
        output_z_ack = 1'b0;
        #2;
        n_cmp++; if (input_a_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got=%b want=0", input_a_ack); end
        n_cmp++; if (output_z_stb !== 1'b0) begin n_bad++; $display("FAIL reset_stb got=%b want=0", output_z_stb); end
        n_cmp++; if (output_z !== 64'd0) begin n_bad++; $display("FAIL reset_z got=%h want=0", output_z); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (input_a_ack !== 1'b1) begin n_bad++; $display("FAIL reset_release_ack got=%b want=1", input_a_ack); end
    endtask

    task automatic test_vectors();
        logic [63:0] va [7];
        logic [63:0] vz [7];
        int          vl [7];
        logic [63:0] z;
        int          lat;
        bit          ok;
        va[0] = 64'd1;                   vz[0] = 64'h3FF0000000000000; vl[0] = 67;
        va[1] = 64'hFFFFFFFFFFFFFFFF;    vz[1] = 64'hBFF0000000000000; vl[1] = 67;
        va[2] = 64'd0;                   vz[2] = 64'h0000000000000000; vl[2] = 2;
        va[3] = 64'h8000000000000000;    vz[3] = 64'hC3E0000000000000; vl[3] = 4;
        va[4] = 64'd9007199254740993;    vz[4] = 64'h4340000000000000; vl[4] = 14;
        va[5] = 64'd9007199254740995;    vz[5] = 64'h4340000000000002; vl[5] = 14;
        va[6] = 64'h7FFFFFFFFFFFFFFF;    vz[6] = 64'h43E0000000000000; vl[6] = 5;
        for (int i = 0; i < 7; i++) begin
            run_one(va[i], 0, z, lat, ok);
            n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL vec%0d_timeout got=%b want=1", i, ok); end
            n_cmp++; if (z !== vz[i]) begin n_bad++; $display("FAIL vec%0d_z a=%h got=%h want=%h", i, va[i], z, vz[i]); end
            n_cmp++; if (lat !== vl[i]) begin n_bad++; $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, vl[i]); end
            n_cmp++; if (output_z_stb !== 1'b0) begin n_bad++; $display("FAIL vec%0d_stb_drop got=%b want=0", i, output_z_stb); end
            n_cmp++; if (input_a_ack !== 1'b1) begin n_bad++; $display("FAIL vec%0d_ack_back got=%b want=1", i, input_a_ack); end
        end
    endtask

    task automatic test_stall();
        logic [63:0] a, junk, z0, z;
        int          lat;
        bit          ok;
        a    = 64'd123456789;
        junk = 64'd42;
        output_z_ack = 1'b0;
        send(a, ok);
        recv(z0, lat, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL stall_timeout got=%b want=1", ok); end
        n_cmp++; if (z0 !== model_z(a)) begin n_bad++; $display("FAIL stall_z got=%h want=%h", z0, model_z(a)); end
        input_a     = junk;
        input_a_stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (output_z_stb !== 1'b1) begin n_bad++; $display("FAIL stall_stb_c%0d got=%b want=1", i, output_z_stb); end
            n_cmp++; if (output_z !== z0) begin n_bad++; $display("FAIL stall_z_stable_c%0d got=%h want=%h", i, output_z, z0); end
            n_cmp++; if (input_a_ack !== 1'b0) begin n_bad++; $display("FAIL stall_ack_c%0d got=%b want=0", i, input_a_ack); end
        end
        input_a_stb  = 1'b0;
        output_z_ack = 1'b1;
        @(posedge clk);
        #1;
        output_z_ack = 1'b0;
        n_cmp++; if (output_z_stb !== 1'b0) begin n_bad++; $display("FAIL stall_release_stb got=%b want=0", output_z_stb); end
        n_cmp++; if (input_a_ack !== 1'b1) begin n_bad++; $display("FAIL stall_release_ack got=%b want=1", input_a_ack); end
        a = 64'hFFFFFFFFFFFF0001;
        run_one(a, 0, z, lat, ok);
        n_cmp++; if (z !== model_z(a)) begin n_bad++; $display("FAIL stall_next_z got=%h want=%h", z, model_z(a)); end
    endtask

    task automatic test_reset_midflight();
        logic [63:0] a, z;
        int          lat;
        bit          ok;
        output_z_ack = 1'b0;
        send(64'd1, ok);
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (output_z_stb !== 1'b0) begin n_bad++; $display("FAIL midrst_busy_stb got=%b want=0", output_z_stb); end
        rst = 1'b1;
        #1;
        n_cmp++; if (output_z_stb !== 1'b0) begin n_bad++; $display("FAIL midrst_stb got=%b want=0", output_z_stb); end
        n_cmp++; if (input_a_ack !== 1'b0) begin n_bad++; $display("FAIL midrst_ack got=%b want=0", input_a_ack); end
        n_cmp++; if (output_z !== 64'd0) begin n_bad++; $display("FAIL midrst_z got=%h want=0", output_z); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (input_a_ack !== 1'b1) begin n_bad++; $display("FAIL midrst_release_ack got=%b want=1", input_a_ack); end
        n_cmp++; if (output_z_stb !== 1'b0) begin n_bad++; $display("FAIL midrst_release_stb got=%b want=0", output_z_stb); end
        a = 64'hFFFFFFFFFFFFCFC7;
        run_one(a, 0, z, lat, ok);
        n_cmp++; if (z !== model_z(a)) begin n_bad++; $display("FAIL midrst_next_z got=%h want=%h", z, model_z(a)); end
        n_cmp++; if (lat !== model_lat(a)) begin n_bad++; $display("FAIL midrst_next_lat got=%0d want=%0d", lat, model_lat(a)); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, z;
        int          lat;
        bit          ok;
        for (int i = 0; i < 1000; i++) begin
            a = rand_operand();
            run_one(a, $urandom_range(0, 3), z, lat, ok);
            n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b%0d_timeout a=%h", i, a); end
            n_cmp++; if (z !== model_z(a)) begin n_bad++; $display("FAIL b2b%0d_z a=%h got=%h want=%h", i, a, z, model_z(a)); end
            n_cmp++; if (lat !== model_lat(a)) begin n_bad++; $display("FAIL b2b%0d_lat a=%h got=%0d want=%0d", i, a, lat, model_lat(a)); end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_stall();
        test_reset_midflight();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
